// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the cache SRAM model.
package sram_pkg;

  typedef enum logic {
    SRAM_IDLE  = 1'b0,
    SRAM_CLEAR = 1'b1
  } sram_state_e;

  // Default geometry of the tag/data arrays this model stands in for.
  localparam int SRAM_DATA_WIDTH_DEF  = 24;
  localparam int SRAM_ADDR_WIDTH_DEF  = 4;
  localparam int SRAM_WMASK_WIDTH_DEF = 3;
  localparam int SRAM_GROUP_DEF       = SRAM_DATA_WIDTH_DEF / SRAM_WMASK_WIDTH_DEF;

  // Bits covered by one write-mask bit.
  function automatic int sram_group(input int data_width, input int wmask_width);
    return data_width / wmask_width;
  endfunction

endpackage

// File: rtl/cache_sram_clear_seq.sv
// Clear sequencer: sweeps every entry with the init value after reset or on
// request, and holds the ports off (ready=0) while it runs.
module cache_sram_clear_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  clear,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  // Last entry of the sweep; compared explicitly so the counter never wraps
  // into a second pass.
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  sram_state_e           state;
  logic [ADDR_WIDTH-1:0] cnt;

  // FSM and sweep counter, with ready/clr_we registered alongside the state.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state  <= SRAM_CLEAR;
      cnt    <= '0;
      ready  <= 1'b0;
      clr_we <= 1'b1;
    end else begin
      case (state)
        SRAM_IDLE: begin
          if (clear) begin
            state  <= SRAM_CLEAR;
            cnt    <= '0;
            ready  <= 1'b0;
            clr_we <= 1'b1;
          end
        end
        SRAM_CLEAR: begin
          // A clear request here is ignored; the running sweep continues.
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= SRAM_IDLE;
            ready  <= 1'b1;
            clr_we <= 1'b0;
          end
        end
        default: begin
          state  <= SRAM_CLEAR;
          cnt    <= '0;
          ready  <= 1'b0;
          clr_we <= 1'b1;
        end
      endcase
    end
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/cache_sram_1rw1r.sv
// Behavioural 1RW + 1R SRAM with per-group write mask and a bulk clear.
// Inputs are registered; reads are combinational from the registered address.
module cache_sram_1rw1r
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SRAM_DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH  = SRAM_ADDR_WIDTH_DEF,
  parameter int                    WMASK_WIDTH = SRAM_WMASK_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  input  logic                   clear,
  output logic                   ready
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int GROUP     = sram_group(DATA_WIDTH, WMASK_WIDTH);

  logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

  logic                   web0_reg;
  logic [WMASK_WIDTH-1:0] wmask0_reg;
  logic [ADDR_WIDTH-1:0]  addr0_reg;
  logic [DATA_WIDTH-1:0]  din0_reg;
  logic [ADDR_WIDTH-1:0]  addr1_reg;
  logic [DATA_WIDTH-1:0]  wbits;

  logic                   clr_we;
  logic [ADDR_WIDTH-1:0]  clr_addr;

  cache_sram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk0     (clk0),
    .rst0     (rst0),
    .clear    (clear),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Port registers: capture only while ready; a write strobe lives one cycle.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      web0_reg  <= 1'b1;
      addr0_reg <= '0;
      addr1_reg <= '0;
    end else begin
      if (ready && !csb0) begin
        web0_reg   <= web0;
        wmask0_reg <= wmask0;
        addr0_reg  <= addr0;
        din0_reg   <= din0;
      end else begin
        web0_reg <= 1'b1;
      end
      if (ready && !csb1) addr1_reg <= addr1;
    end
  end

  // Expand the group mask to a per-bit write mask.
  always_comb begin
    wbits = '0;
    for (int g = 0; g < WMASK_WIDTH; g++)
      wbits[g*GROUP +: GROUP] = {GROUP{wmask0_reg[g]}};
  end

  // Array update; the clear write is issued last so it wins on the same entry.
  // Nothing is written on a reset edge, which also drops a pending write.
  always_ff @(posedge clk0) begin
    if (!rst0) begin
      if (!web0_reg)
        mem[addr0_reg] <= (mem[addr0_reg] & ~wbits) | (din0_reg & wbits);
      if (clr_we)
        mem[clr_addr] <= INIT_VALUE;
    end
  end

  assign dout0 = mem[addr0_reg];
  assign dout1 = mem[addr1_reg];

endmodule

// File: doc/cache_sram_1rw1r.md
# cache_sram_1rw1r

Parametrised behavioural SRAM model for cache tag and data arrays: one read/write port with per-group write mask, one independent read-only port, and a built-in clear sequencer that writes a constant to every entry after reset or on request. It replaces the fixed-size single-port macro models where a cache needs bulk invalidation, a second lookup port, or partial-word writes. It sits directly under the cache datapath, with the same registered-input, asynchronous-read timing as the existing macro models.

## Interface
- DATA_WIDTH, 24, bits per word.
- ADDR_WIDTH, 4, address bits; RAM_DEPTH = 1 << ADDR_WIDTH.
- WMASK_WIDTH, 3, write-mask groups; DATA_WIDTH % WMASK_WIDTH == 0; GROUP = DATA_WIDTH / WMASK_WIDTH.
- INIT_VALUE, '0, DATA_WIDTH-bit value written by the clear sequencer.
- clk0  in  1  clock; all state on posedge.
- rst0  in  1  reset, synchronous, active-high.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  WMASK_WIDTH  port 0 group write enables, bit i covers din0[i*GROUP +: GROUP].
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- csb1  in  1  port 1 chip select, active low, read only.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.
- clear  in  1  single-cycle request to re-initialise the whole array.
- ready  out  1  high when ports accept requests; low during reset and clear.

## Operation
- Capture: at an edge with ready=1 and csb0=0, register web0, wmask0, addr0 and din0. At an edge with ready=1 and csb1=0, register addr1. While ready=0, or while a chip select is high, the port registers hold their values.
- Write: a captured write (web0_reg=0) commits at the next edge. Only the groups with wmask0_reg[i]=1 are written. wmask0=0 is a legal no-op write. web0_reg returns to 1 unless another write is captured at that edge.
- Read: dout0 = mem[addr0_reg] and dout1 = mem[addr1_reg], combinational from the registered addresses. The outputs hold until the next capture on the same port, and follow any commit to that address.
- Clear FSM states: IDLE and CLEAR.
  - rst0=1 forces CLEAR with cnt=0 and web0_reg=1, which cancels any pending write. addr0_reg and addr1_reg reset to 0.
  - In CLEAR, each edge with rst0=0 writes INIT_VALUE to mem[cnt] on all bits, ignoring the mask, then increments cnt. The edge that writes entry RAM_DEPTH-1 moves the FSM to IDLE.
  - In IDLE, clear=1 at an edge moves the FSM to CLEAR with cnt=0.
  - ready = (state == IDLE).
- Boundaries:
  - clear during CLEAR is ignored; the sweep is not restarted.
  - rst0 during CLEAR restarts the sweep at cnt=0.
  - A write captured on the edge that samples clear commits at the first CLEAR edge. If it targets entry 0, INIT_VALUE wins. Otherwise both writes land.
  - cnt is ADDR_WIDTH+1 bits or uses an explicit terminal compare; there is no wrap-around re-sweep.

## Timing
- Read latency: data is valid on dout after the capture edge (same cycle, combinational).
- Write: mem is updated one edge after capture. A port-1 read of the same address shows old data until that edge and new data after it.
- Clear duration: exactly RAM_DEPTH edges after rst0 deasserts (or after clear is sampled). ready rises after the final clear write.
- Reset values:
  - ready=0.
  - dout0 and dout1 = mem[0], which equals INIT_VALUE from the first clear edge onward.

## Structure
- Package sram_pkg:
  - sram_state_e, with values SRAM_IDLE and SRAM_CLEAR.
  - A helper localparam for the GROUP computation.
- Sub-module cache_sram_clear_seq: FSM plus counter. Outputs ready, clr_we and clr_addr.
- The top module holds the memory array, the port registers, mask expansion and write arbitration. The clear write has priority over a port-0 write.

## Test plan
- Reset clear: set mem to random values, pulse rst0 for 2 cycles -> ready=0 for 16 edges, then 1; port-0 reads of addr 0..15 all return 24'h000000.
- Masked write: write din0=24'hABCDEF with wmask0=3'b101 to addr 5, which held 24'h000000 -> after commit, a read of addr 5 returns 24'hAB00EF.
- Dual-port collision: write 24'h123456 to addr 3 while port 1 reads addr 3 -> dout1 shows the old value, then 24'h123456 from the commit edge.
- Requests while not ready: assert csb0=0 and web0=0 at addr 7 during CLEAR -> no write; addr 7 reads INIT_VALUE after ready.
- Write racing clear: capture a write to addr 0 on the same edge that clear=1 is sampled -> addr 0 reads INIT_VALUE. Repeat with addr 9 -> addr 9 also reads INIT_VALUE after the sweep.
- Reset mid-clear: assert rst0 at cnt=8 -> ready stays 0 for 16 more edges after rst0 drops; all entries read INIT_VALUE.
